// File: rtl/da_lut_gen.sv
// Builds the 16-entry distributed-arithmetic LUT from four signed coefficients
// and streams it into the FIR controller's coefficient ROM, then pulses start.
module da_lut_gen #(
  parameter int COEF_W = 8,
  parameter int LUT_W  = COEF_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              build,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic              CLOAD,
  output logic              lut_valid,
  output logic [3:0]        lut_addr,
  output logic [LUT_W-1:0]  lut_data,
  output logic              start,
  output logic              loaded,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, GEN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        k_q, k_d;
  logic [COEF_W-1:0] c_q [4];
  logic              accept;

  logic              coef_ready_d, gen_d, start_d, loaded_d, busy_d;
  logic [3:0]        lut_addr_d;
  logic [LUT_W-1:0]  lut_data_d;

  // Handshake: a coefficient transfers on any rising edge where coef_valid and
  // coef_ready are both high; coef_ready is high exactly while in COLLECT.
  assign accept = (state_q == COLLECT) && coef_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      k_q        <= 4'd0;
      for (int i = 0; i < 4; i++) c_q[i] <= '0;
      coef_ready <= 1'b0;
      CLOAD      <= 1'b0;
      lut_valid  <= 1'b0;
      lut_addr   <= 4'd0;
      lut_data   <= '0;
      start      <= 1'b0;
      loaded     <= 1'b0;
      busy       <= 1'b0;
      fsm_state  <= IDLE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      if (accept) c_q[idx_q] <= coef_in;
      coef_ready <= coef_ready_d;
      CLOAD      <= gen_d;
      lut_valid  <= gen_d;
      lut_addr   <= lut_addr_d;
      lut_data   <= lut_data_d;
      start      <= start_d;
      loaded     <= loaded_d;
      busy       <= busy_d;
      fsm_state  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (build) begin
          state_d = COLLECT;
          idx_d   = 2'd0;
        end
      end
      COLLECT: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = GEN;
            k_d     = 4'd0;
          end
        end
      end
      GEN: begin
        if (k_q == 4'd15) state_d = DONE;
        else              k_d     = k_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state and registered. Entry 0 has no
  // terms, so the c3 write landing on the same edge never affects a sum.
  always_comb begin
    coef_ready_d = (state_d == COLLECT);
    gen_d        = (state_d == GEN);
    start_d      = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    lut_addr_d   = gen_d ? k_d : 4'd0;
    lut_data_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (gen_d && k_d[i]) lut_data_d = lut_data_d + LUT_W'($signed(c_q[i]));
    end
    loaded_d = loaded;
    if (state_q == IDLE && state_d == COLLECT) loaded_d = 1'b0;
    else if (state_d == DONE)                  loaded_d = 1'b1;
  end

endmodule

// File: tb/tb_da_lut_gen.sv
// Self-checking bench for da_lut_gen: directed vector table, stall/ignore/reset
// sequences and randomized builds checked against an arithmetic LUT model.
module tb_da_lut_gen;
  localparam int COEF_W = 8;
  localparam int LUT_W  = 10;

  typedef int coef_arr_t [4];
  typedef struct {
    int c0, c1, c2, c3;
    int addr;
    int val;
    int mode;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset, build, coef_valid;
  logic [COEF_W-1:0] coef_in;
  logic              coef_ready, CLOAD, lut_valid, start, loaded, busy;
  logic [3:0]        lut_addr;
  logic [LUT_W-1:0]  lut_data;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;
  int obs [16];
  logic [LUT_W-1:0] exp_q [$];

  da_lut_gen #(.COEF_W(COEF_W), .LUT_W(LUT_W)) dut (
    .clk(clk), .reset(reset), .build(build), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .CLOAD(CLOAD),
    .lut_valid(lut_valid), .lut_addr(lut_addr), .lut_data(lut_data),
    .start(start), .loaded(loaded), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: entry k is the plain integer sum of the coefficients whose
  // index bit is set in k.
  function automatic int model_entry(input coef_arr_t c, input int k);
    int s = 0;
    for (int i = 0; i < 4; i++) if (((k >> i) & 1) == 1) s += c[i];
    return s;
  endfunction

  // mode 0: back-to-back, 1: valid pattern 1,0,0,1,0,1,1, 2: random valid.
  task automatic feed(input coef_arr_t c, input int mode);
    int n;
    int cyc;
    int pat [7];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    build = 1'b1;
    step();
    build = 1'b0;
    check("ready_after_build", int'(coef_ready), 1);
    check("busy_after_build", int'(busy), 1);
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 200) begin
      bit v;
      bit rdy;
      rdy = coef_ready;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc < 7) ? pat[cyc][0] : 1'b1;
      else                v = 1'($urandom_range(0, 1));
      coef_valid = v;
      coef_in    = v ? COEF_W'(c[n]) : COEF_W'($urandom);
      if (lut_valid) check("collect_lut_valid", int'(lut_valid), 0);
      if (v && rdy) n++;
      step();
      cyc++;
    end
    coef_valid = 1'b0;
    if (n < 4) check("collect_timeout", n, 4);
    if (mode == 1) check("stall_cycles", cyc, 7);
  endtask

  task automatic gen_phase(input coef_arr_t c, input bit disturb);
    for (int k = 0; k < 16; k++) exp_q.push_back(LUT_W'(model_entry(c, k)));
    for (int k = 0; k < 16; k++) begin
      logic [LUT_W-1:0] e;
      if (disturb && k >= 4 && k < 7) begin
        build = 1'b1; coef_valid = 1'b1; coef_in = 8'd99;
      end else begin
        build = 1'b0; coef_valid = 1'b0;
      end
      e = exp_q.pop_front();
      check("gen_lut_valid", int'(lut_valid), 1);
      check("gen_cload", int'(CLOAD), 1);
      check("gen_addr", int'(lut_addr), k);
      check("gen_data", int'(lut_data), int'(e));
      check("gen_no_start", int'(start), 0);
      obs[k] = int'($signed(lut_data));
      step();
    end
    build = 1'b0;
    coef_valid = 1'b0;
    check("done_start", int'(start), 1);
    check("done_loaded", int'(loaded), 1);
    check("done_lut_valid", int'(lut_valid), 0);
    check("done_cload", int'(CLOAD), 0);
    check("done_busy", int'(busy), 1);
    step();
    check("idle_start", int'(start), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_state", int'(fsm_state), 0);
    check("idle_loaded", int'(loaded), 1);
    check("idle_ready", int'(coef_ready), 0);
    if (disturb) begin
      step();
      check("no_restart_busy", int'(busy), 0);
    end
  endtask

  task automatic run_build(input coef_arr_t c, input int mode, input bit disturb);
    feed(c, mode);
    gen_phase(c, disturb);
  endtask

  initial begin
    vec_t      vecs [6];
    int        nom [16];
    coef_arr_t c;
    coef_arr_t cn;
    int        bound;
    bit        saw_start;

    nom  = '{0, 3, -2, 1, 5, 8, 3, 6, 7, 10, 5, 8, 12, 15, 10, 13};
    cn   = '{3, -2, 5, 7};
    vecs[0] = '{c0: 3,    c1: -2,   c2: 5,    c3: 7,    addr: 15, val: 13,   mode: 0};
    vecs[1] = '{c0: 3,    c1: -2,   c2: 5,    c3: 7,    addr: 5,  val: 8,    mode: 1};
    vecs[2] = '{c0: 127,  c1: 127,  c2: 127,  c3: 127,  addr: 15, val: 508,  mode: 0};
    vecs[3] = '{c0: -128, c1: -128, c2: -128, c3: -128, addr: 15, val: -512, mode: 0};
    vecs[4] = '{c0: -128, c1: -128, c2: -128, c3: -128, addr: 3,  val: -256, mode: 2};
    vecs[5] = '{c0: 3,    c1: -2,   c2: 5,    c3: 7,    addr: 0,  val: 0,    mode: 2};

    reset = 1'b1; build = 1'b1; coef_valid = 1'b1; coef_in = 8'd5;
    step();
    step();
    check("rst_ready", int'(coef_ready), 0);
    check("rst_cload", int'(CLOAD), 0);
    check("rst_lut_valid", int'(lut_valid), 0);
    check("rst_addr", int'(lut_addr), 0);
    check("rst_data", int'(lut_data), 0);
    check("rst_start", int'(start), 0);
    check("rst_loaded", int'(loaded), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(fsm_state), 0);
    reset = 1'b0; build = 1'b0; coef_valid = 1'b0;
    step();
    check("post_rst_ready", int'(coef_ready), 0);
    check("post_rst_busy", int'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      c = '{vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3};
      run_build(c, vecs[v].mode, 1'b0);
      check("vec_entry", obs[vecs[v].addr], vecs[v].val);
    end

    run_build(cn, 0, 1'b0);
    for (int k = 0; k < 16; k++) check("nominal_table", obs[k], nom[k]);

    run_build(cn, 0, 1'b1);
    for (int k = 0; k < 16; k++) check("ignored_inputs_table", obs[k], nom[k]);

    // Reset while the table is streaming out at address 6.
    feed(cn, 0);
    bound = 0;
    while (!(lut_valid && lut_addr == 4'd6) && bound < 40) begin
      step();
      bound++;
    end
    check("reach_addr6", int'(lut_addr), 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midgen_lut_valid", int'(lut_valid), 0);
    check("midgen_cload", int'(CLOAD), 0);
    check("midgen_loaded", int'(loaded), 0);
    check("midgen_busy", int'(busy), 0);
    saw_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start || lut_valid) saw_start = 1'b1;
      step();
    end
    check("midgen_no_activity", int'(saw_start), 0);
    check("midgen_loaded_after", int'(loaded), 0);
    run_build(cn, 0, 1'b0);
    for (int k = 0; k < 16; k++) check("rebuild_table", obs[k], nom[k]);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 255)) - 128;
      run_build(c, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_lut_gen.md
# da_lut_gen

Upstream companion to the distributed-arithmetic FIR controller. It accepts the four raw signed filter coefficients over a valid/ready handshake and computes the 16 DA lookup-table partial sums. It streams those sums, with addresses, into the coefficient ROM using the controller's load interface (`CLOAD` plus a write strobe). It then issues a one-cycle `start` pulse, so the controller only begins filtering once the ROM is fully populated.

## Interface
- `COEF_W`, default 8: width of each signed input coefficient.
- `LUT_W`, default `COEF_W+2`: width of each signed LUT entry. This is the minimum width that holds a sum of 4 coefficients.
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `build`, input, 1: single-cycle request to (re)build the LUT. Honoured only in IDLE.
- `coef_in`, input, `COEF_W`: signed coefficient. The order is c0, c1, c2, c3.
- `coef_valid`, input, 1: `coef_in` is valid.
- `coef_ready`, output, 1: block accepts a coefficient this cycle.
- `CLOAD`, output, 1: ROM load mode. High for the whole GEN state.
- `lut_valid`, output, 1: `lut_addr`/`lut_data` hold an entry to write. Feeds the controller's `valid_in`.
- `lut_addr`, output, 4: ROM address of the current entry.
- `lut_data`, output, `LUT_W`: signed partial sum for `lut_addr`.
- `start`, output, 1: one-cycle pulse after the last entry is written.
- `loaded`, output, 1: level signal, high once a full LUT has been written since the last reset or build.
- `busy`, output, 1: high in COLLECT, GEN and DONE.

## Operation
- The FSM has four states: IDLE, COLLECT, GEN and DONE.
- **IDLE**
  - `build`=1 → COLLECT. The coefficient index is cleared to 0 and `loaded` is cleared to 0.
  - `build` while in any other state is ignored.
- **COLLECT**
  - `coef_ready`=1.
  - On `coef_valid & coef_ready`, store `coef_in` into c[idx] and increment idx.
  - On acceptance of c3 → GEN, with the entry counter k=0.
  - `coef_valid` outside COLLECT is ignored and has no effect on c[].
- **GEN**
  - Lasts exactly 16 cycles, k = 0..15.
  - Each cycle drives `lut_valid`=1, `lut_addr`=k and `lut_data`=Σ c[i] over bits i set in k.
  - Each c[i] is sign-extended to `LUT_W` before summing. Bit 0 of k selects c0 and bit 3 selects c3.
  - Entry 0 is always 0.
  - After k=15 → DONE.
- **DONE**
  - Lasts one cycle, with `start`=1 and `loaded` set to 1.
  - Then → IDLE.
- Arithmetic: the sum never overflows at `LUT_W`, so no saturation or truncation logic exists.
- Every LUT entry is written; none are skipped. A rebuild via `build` overwrites all 16 entries.

## Timing
- All outputs are registered and change only on the rising edge of `clk`. They are therefore stable when the controller samples them on the falling edge.
- Reset values: `coef_ready`=0, `CLOAD`=0, `lut_valid`=0, `lut_addr`=0, `lut_data`=0, `start`=0, `loaded`=0, `busy`=0. State is IDLE and c0..c3 are 0.
- Reset has priority over every other input, including a simultaneous `build` or `coef_valid`.
- Reset mid-COLLECT or mid-GEN: the block returns to IDLE on the next edge, no further `lut_valid`, no `start`, and `loaded`=0.
- Latency from `build` in cycle T:
  - `coef_ready`=1 from T+1.
  - If c3 is accepted in cycle A, the entry with k=0 is presented in A+1 and k=15 in A+16.
  - `start`=1 in A+17.
  - `busy`=0 and IDLE in A+18.
- Coefficient stalls: `coef_valid` may drop at any time in COLLECT. The block waits indefinitely, and idx advances only on a handshake.
- `CLOAD` and `lut_valid` are asserted and deasserted on the same edges. Both are low in the DONE cycle.
- `start` is never asserted unless all 16 entries were presented consecutively after the most recent reset or build.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `build`=1 → every output 0, state IDLE, and `coef_ready`=0 on the cycle after release.
- **Nominal build:** `build`, then coefficients 3, −2, 5, 7 back-to-back → 16 consecutive entries:
  - addr 0..7 = 0, 3, −2, 1, 5, 8, 3, 6.
  - addr 8..15 = 7, 10, 5, 8, 12, 15, 10, 13.
  - `start` pulses exactly once in the cycle after addr 15, and `loaded`=1 from that point.
- **Extremes:** all coefficients +127 → addr 15 = 508. All coefficients −128 → addr 15 = −512, addr 3 = −256. No wrap at `LUT_W`=10.
- **Handshake stalls:** `coef_valid` toggled 1,0,0,1,0,1,1 → exactly 4 coefficients captured in order, and the first `lut_valid` appears on the cycle after the 4th handshake.
- **Ignored inputs:** pulse `build` and drive `coef_valid`=1 with value 99 during GEN → the entry sequence is unchanged, no restart occurs, and c[] is unchanged.
- **Reset mid-GEN:** assert `reset` at addr 6 → `lut_valid`/`CLOAD` low on the next cycle, no `start`, `loaded`=0. A subsequent full build produces the correct table.
